// File: rtl/paralelo_serial_tx_pkg.sv
// Shared PHY definitions for the serial lane: fill symbol, slot timing, FSM encoding.
// The phy_rx receiver imports the same package.
package paralelo_serial_tx_pkg;

   localparam logic [7:0]  COMMA_SYM   = 8'hBC;
   localparam logic [1:0]  SLOT_LAST   = 2'b11;
   localparam int unsigned N_TRAIN_DEF = 4;

   typedef enum logic {
      ST_TRAIN = 1'b0,
      ST_DATA  = 1'b1
   } tx_state_e;

   // Symbol to put on the wire for a {valid, data} word: invalid words become fill.
   function automatic logic [7:0] word_sym(input logic [8:0] word, input logic [7:0] comma);
      return word[8] ? word[7:0] : comma;
   endfunction

endpackage

// File: rtl/ps_tx_shifter.sv
// Symbol shift register for the serial TX lane. Loads a full symbol on the last slot,
// otherwise shifts left by one pair; the top pair is the line output.
module ps_tx_shifter
   import paralelo_serial_tx_pkg::*;
#(
   parameter logic [7:0] RESET_SYM = COMMA_SYM
) (
   input  logic       clk16,
   input  logic       reset16,
   input  logic       load,
   input  logic [7:0] load_sym,
   output logic [1:0] outSerial
);

   logic [7:0] sym;

   // Load a new symbol or shift out the next pair; reset aborts any in-flight symbol
   always_ff @(posedge clk16) begin
      if (!reset16) begin
         sym <= RESET_SYM;
      end else if (load) begin
         sym <= load_sym;
      end else begin
         sym <= {sym[5:0], 2'b00};
      end
   end

   assign outSerial = sym[7:6];

endmodule

// File: rtl/paralelo_serial_tx.sv
// Transmit half of the 2-bit serial PHY lane. Serialises 9-bit {valid, data} words into
// four 2-bit symbols MSB pair first, sending comma fill for invalid words and an N_TRAIN
// comma preamble after reset.
// Optional: define PS_TX_STATS_EN to add the data_count port (valid words sent).
module paralelo_serial_tx
   import paralelo_serial_tx_pkg::*;
#(
   parameter logic [7:0]  COMMA   = COMMA_SYM,
   parameter int unsigned N_TRAIN = N_TRAIN_DEF
) (
   input  logic        clk16,
   input  logic        reset16,
   input  logic [8:0]  inParalelo,
   output logic [1:0]  outSerial,
   output logic        in_ready,
   output logic        tx_active,
   output logic        comma_collision
`ifdef PS_TX_STATS_EN
   ,
   output logic [15:0] data_count
`endif
);

   localparam logic [3:0] TRAIN_LAST = 4'(N_TRAIN - 1);

   logic [1:0] i;
   tx_state_e  state;
   logic [3:0] train_cnt;
   logic       slot_last;
   logic [7:0] load_sym;

   assign slot_last = (i == SLOT_LAST);
   assign tx_active = (state == ST_DATA);

   // Handshake: every last slot in DATA, only the final preamble slot in TRAIN
   always_comb begin
      in_ready = slot_last && ((state == ST_DATA) || (train_cnt == TRAIN_LAST));
   end

   // Next symbol: captured word on a sampling edge, otherwise training fill
   always_comb begin
      load_sym = COMMA;
      if (in_ready) begin
         load_sym = word_sym(inParalelo, COMMA);
      end
   end

   // Slot counter, training FSM and registered collision pulse
   always_ff @(posedge clk16) begin
      if (!reset16) begin
         i               <= '0;
         state           <= ST_TRAIN;
         train_cnt       <= '0;
         comma_collision <= 1'b0;
      end else begin
         i               <= i + 2'd1;
         comma_collision <= in_ready && inParalelo[8] && (inParalelo[7:0] == COMMA);
         if ((state == ST_TRAIN) && slot_last) begin
            if (in_ready) begin
               state <= ST_DATA;
            end else begin
               train_cnt <= train_cnt + 4'd1;
            end
         end
      end
   end

`ifdef PS_TX_STATS_EN
   // Count valid words captured on sampling edges; wraps naturally at 16 bits
   always_ff @(posedge clk16) begin
      if (!reset16) begin
         data_count <= '0;
      end else if (in_ready && inParalelo[8]) begin
         data_count <= data_count + 16'd1;
      end
   end
`endif

   ps_tx_shifter #(
      .RESET_SYM (COMMA)
   ) u_shifter (
      .clk16     (clk16),
      .reset16   (reset16),
      .load      (slot_last),
      .load_sym  (load_sym),
      .outSerial (outSerial)
   );

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: hand sequences, a vector table and random
// traffic against a symbol-stream reference model.
module tb_paralelo_serial_tx;

   localparam logic [7:0]  COMMA   = 8'hBC;
   localparam int unsigned N_TRAIN = 4;

   logic       clk16 = 1'b0;
   logic       reset16;
   logic [8:0] inParalelo;
   logic [1:0] outSerial;
   logic       in_ready;
   logic       tx_active;
   logic       comma_collision;
`ifdef PS_TX_STATS_EN
   logic [15:0] data_count;
`endif

   paralelo_serial_tx #(
      .COMMA   (COMMA),
      .N_TRAIN (N_TRAIN)
   ) dut (
      .clk16           (clk16),
      .reset16         (reset16),
      .inParalelo      (inParalelo),
      .outSerial       (outSerial),
      .in_ready        (in_ready),
      .tx_active       (tx_active),
      .comma_collision (comma_collision)
`ifdef PS_TX_STATS_EN
      ,
      .data_count      (data_count)
`endif
   );

   always #5 clk16 = ~clk16;

   typedef struct packed {
      logic [1:0] os;
      logic       rdy;
      logic       act;
      logic       coll;
   } obs_t;

   typedef struct packed {
      logic [8:0] word;
      logic [7:0] pairs;  // expected outSerial pairs, first pair in [7:6]
      logic       coll;
   } vec_t;

   int passes = 0;
   int total  = 0;

   // Reference model: cycle index since reset, words sampled per symbol slot
   int          k = 0;
   logic [8:0]  samp [int];
   logic [15:0] cnt_model = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passes++;
      else $display("FAIL %s at k=%0d: got %0h want %0h", name, k, got, exp);
   endtask

   function automatic logic [7:0] exp_sym(input int s);
      if (s < int'(N_TRAIN)) return COMMA;
      if (!samp.exists(s)) return COMMA;
      return samp[s][8] ? samp[s][7:0] : COMMA;
   endfunction

   // Drive one cycle, check against the model, then advance the model on the edge
   task automatic run_cycle(input logic [8:0] word, input logic rst_n, output obs_t o);
      logic [7:0] sh;
      logic       e_rdy, e_act, e_coll;
      int         s, p;
      inParalelo = word;
      reset16    = rst_n;
      @(negedge clk16);
      o.os   = outSerial;
      o.rdy  = in_ready;
      o.act  = tx_active;
      o.coll = comma_collision;
      s      = k / 4;
      p      = k % 4;
      sh     = exp_sym(s) >> (6 - 2 * p);
      e_rdy  = (p == 3) && (k >= 4 * int'(N_TRAIN) - 1);
      e_act  = (k >= 4 * int'(N_TRAIN));
      e_coll = (p == 0) && (s >= int'(N_TRAIN)) && samp.exists(s) && samp[s][8] &&
               (samp[s][7:0] == COMMA);
      chk("outSerial", 32'(o.os), 32'(sh[1:0]));
      chk("in_ready", 32'(o.rdy), 32'(e_rdy));
      chk("tx_active", 32'(o.act), 32'(e_act));
      chk("comma_collision", 32'(o.coll), 32'(e_coll));
`ifdef PS_TX_STATS_EN
      chk("data_count", 32'(data_count), 32'(cnt_model));
`endif
      @(posedge clk16);
      if (!rst_n) begin
         k = 0;
         samp.delete();
         cnt_model = '0;
      end else begin
         if (e_rdy) begin
            samp[(k + 1) / 4] = word;
            if (word[8]) cnt_model = cnt_model + 16'd1;
         end
         k++;
      end
      #1;
   endtask

   task automatic align_ready();
      obs_t o;
      while ((k % 4) != 3) run_cycle(9'h000, 1'b1, o);
   endtask

   vec_t vecs [3];

   initial begin
      obs_t        o;
      logic [7:0]  sh;
      logic [8:0]  w;
      logic        r;
      logic [7:0]  pat;

      vecs[0] = '{word: 9'h1A5, pairs: 8'hA5, coll: 1'b0};
      vecs[1] = '{word: 9'h05A, pairs: 8'hBC, coll: 1'b0};
      vecs[2] = '{word: 9'h1BC, pairs: 8'hBC, coll: 1'b1};

      reset16    = 1'b0;
      inParalelo = 9'h000;
      repeat (2) @(posedge clk16);
      #1;
      k = 0;

      // Reset release with idle input: preamble pattern and handshake timing
      pat = COMMA;
      for (int c = 0; c < 17; c++) begin
         run_cycle(9'h000, 1'b1, o);
         sh = pat >> (6 - 2 * (c % 4));
         chk("preamble_out", 32'(o.os), 32'(sh[1:0]));
         chk("preamble_rdy", 32'(o.rdy), 32'(c == 15));
         chk("preamble_act", 32'(o.act), 32'(c == 16));
      end

      // Vector table: one word per sampling edge, check the four following pairs
      foreach (vecs[n]) begin
         align_ready();
         run_cycle(vecs[n].word, 1'b1, o);
         for (int j = 0; j < 4; j++) begin
            run_cycle(9'h000, 1'b1, o);
            sh = vecs[n].pairs >> (6 - 2 * j);
            chk("vec_out", 32'(o.os), 32'(sh[1:0]));
            chk("vec_coll", 32'(o.coll), 32'((j == 0) && vecs[n].coll));
         end
      end

      // Reset in the middle of a data symbol (i=1)
      align_ready();
      run_cycle(9'h1A5, 1'b1, o);
      run_cycle(9'h000, 1'b1, o);
      run_cycle(9'h000, 1'b0, o);
      for (int c = 0; c < 16; c++) begin
         run_cycle(9'h000, 1'b1, o);
         if (c == 0) chk("midrst_out", 32'(o.os), 32'(2'b10));
         chk("midrst_rdy", 32'(o.rdy), 32'(c == 15));
         chk("midrst_act", 32'(o.act), 32'(0));
      end

      // Reset held at a sampling edge: no capture, no pulse
      run_cycle(9'h000, 1'b1, o);
      align_ready();
      run_cycle(9'h1BC, 1'b0, o);
      run_cycle(9'h000, 1'b1, o);
      chk("rst_edge_coll", 32'(o.coll), 32'(0));
      chk("rst_edge_out", 32'(o.os), 32'(2'b10));

`ifdef PS_TX_STATS_EN
      // Back-to-back words: three valid out of four
      for (int c = 0; c < 16; c++) run_cycle(9'h000, 1'b1, o);
      align_ready();
      run_cycle(9'h1A5, 1'b1, o);
      align_ready();
      run_cycle(9'h13C, 1'b1, o);
      align_ready();
      run_cycle(9'h000, 1'b1, o);
      align_ready();
      run_cycle(9'h1FF, 1'b1, o);
      chk("stats_count", 32'(data_count), 32'(3));
      run_cycle(9'h000, 1'b0, o);
      chk("stats_reset", 32'(data_count), 32'(0));
`endif

      // Random traffic with occasional resets
      for (int c = 0; c < 800; c++) begin
         w = 9'($urandom);
         if ($urandom_range(0, 7) == 0) w = {1'b1, COMMA};
         r = ($urandom_range(0, 99) != 0);
         run_cycle(w, r, o);
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
